// File: rtl/recip_seq_ctrl.sv
// Sequenced reciprocal: reads a 16-bit divisor from memory, computes
// floor(32768/divisor) by restoring division and writes it back.
module recip_seq_ctrl #(
    parameter logic [7:0]  OP_ADDR     = 8'd8,
    parameter logic [7:0]  RES_ADDR    = 8'd10,
    parameter logic [15:0] ZERO_RESULT = 16'h0001
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic       busy,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    typedef enum logic [3:0] {
        IDLE, ARMED, RD_HI, RD_LO, CHECK,
        DIVIDE, WR_HI, WR_LO, DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_div;
    logic [15:0] r_quo;
    logic [16:0] r_rem;
    logic [3:0]  r_cnt;

    logic        w_num_bit;
    logic [16:0] w_rem17;
    logic [16:0] w_diff;
    logic        w_ge;

    // Numerator is 16'h8000: only the first (MSB) step shifts in a one.
    assign w_num_bit = (r_cnt == 4'd15);
    assign w_rem17   = {r_rem[15:0], w_num_bit};
    assign w_diff    = w_rem17 - {1'b0, r_div};
    assign w_ge      = r_rem[16] || (w_rem17 >= {1'b0, r_div});

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (Start) w_next = ARMED;
            ARMED:   if (!Start) w_next = RD_HI;
            RD_HI:   w_next = RD_LO;
            RD_LO:   w_next = CHECK;
            CHECK:   w_next = (r_div == 16'd0) ? WR_HI : DIVIDE;
            DIVIDE:  if (r_cnt == 4'd0) w_next = WR_HI;
            WR_HI:   w_next = WR_LO;
            WR_LO:   w_next = DONE;
            DONE:    if (Start) w_next = ARMED;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_div <= 16'd0;
            r_quo <= 16'd0;
            r_rem <= 17'd0;
            r_cnt <= 4'd0;
        end else begin
            unique case (r_state)
                RD_HI: r_div[15:8] <= mem_rd_data;
                RD_LO: r_div[7:0]  <= mem_rd_data;
                CHECK: begin
                    if (r_div == 16'd0) begin
                        r_quo <= ZERO_RESULT;
                    end else begin
                        r_rem <= 17'd0;
                        r_quo <= 16'd0;
                        r_cnt <= 4'd15;
                    end
                end
                DIVIDE: begin
                    r_rem <= w_ge ? w_diff : w_rem17;
                    r_quo <= {r_quo[14:0], w_ge};
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Ack         = 1'b0;
        busy        = 1'b0;
        mem_addr    = 8'h00;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;
        unique case (r_state)
            RD_HI: begin
                busy     = 1'b1;
                mem_addr = OP_ADDR;
            end
            RD_LO: begin
                busy     = 1'b1;
                mem_addr = OP_ADDR + 8'd1;
            end
            CHECK, DIVIDE: busy = 1'b1;
            WR_HI: begin
                busy        = 1'b1;
                mem_addr    = RES_ADDR;
                mem_wr_data = r_quo[15:8];
                mem_wr_en   = !Reset;
            end
            WR_LO: begin
                busy        = 1'b1;
                mem_addr    = RES_ADDR + 8'd1;
                mem_wr_data = r_quo[7:0];
                mem_wr_en   = !Reset;
            end
            DONE:    Ack = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_recip_seq_ctrl.sv
// Scoreboard bench for recip_seq_ctrl: expected results queued at launch,
// checked by a monitor when Ack rises.
module tb_recip_seq_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic       busy;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] mem [0:255];

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic prev_ack = 1'b0;

    recip_seq_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Ack         (Ack),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    always #5 Clk = ~Clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge Clk) begin
        if (mem_wr_en) mem[mem_addr] = mem_wr_data;
        cyc = cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each Ack rising edge must match the oldest queued run.
    always @(negedge Clk) begin
        exp_t e;
        if (Ack && !prev_ack) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("res_hi", int'(mem[10]), int'(e.hi));
                check("res_lo", int'(mem[11]), int'(e.lo));
                check("ack_edge", cyc, e.cyc);
            end
        end
        prev_ack = Ack;
    end

    task automatic start_run(input logic [15:0] d, output int e0);
        @(negedge Clk);
        mem[8] = d[15:8];
        mem[9] = d[7:0];
        Start  = 1'b1;
        @(negedge Clk);
        Start  = 1'b0;
        e0     = cyc + 1;
    endtask

    task automatic launch(input logic [15:0] d, input logic [15:0] r,
                          input int lat, output int e0);
        exp_t e;
        start_run(d, e0);
        e.hi  = r[15:8];
        e.lo  = r[7:0];
        e.cyc = e0 + lat;
        sb.push_back(e);
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!Ack && n < 40) begin
            @(negedge Clk);
            n++;
        end
        if (!Ack) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack expected ack within 40 cycles");
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge Clk);
    endtask

    initial begin
        int e0;
        exp_t e;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        Reset = 1'b1;
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_ack", int'(Ack), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_en", int'(mem_wr_en), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wdata", int'(mem_wr_data), 0);

        Start = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_prio_busy", int'(busy), 0);

        launch(16'd36, 16'h038E, 21, e0);
        wait_ack();
        launch(16'd1, 16'h8000, 21, e0);
        wait_ack();
        launch(16'd4, 16'h2000, 21, e0);
        wait_ack();
        launch(16'hFFFF, 16'h0000, 21, e0);
        wait_ack();
        launch(16'd0, 16'h0001, 5, e0);
        wait_ack();

        // Reset sampled on the edge ending the 8th DIVIDE cycle.
        start_run(16'd9, e0);
        wait_until(e0 + 10);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midrst_ack", int'(Ack), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_hi", int'(mem[10]), 8'h00);
        check("midrst_lo", int'(mem[11]), 8'h01);

        launch(16'd7, 16'h1249, 21, e0);
        wait_ack();

        launch(16'd5, 16'h1999, 21, e0);
        wait_until(e0 + 8);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_ack();

        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        check("done_ack_drop", int'(Ack), 0);
        check("armed_busy", int'(busy), 0);
        mem[8] = 8'h00;
        mem[9] = 8'h03;
        Start  = 1'b0;
        e.hi   = 8'h2A;
        e.lo   = 8'hAA;
        e.cyc  = cyc + 1 + 21;
        sb.push_back(e);
        wait_ack();
        launch(16'd300, 16'h006D, 21, e0);
        wait_ack();

        // Reset held across the WR_HI cycle must block the write.
        start_run(16'd2, e0);
        wait_until(e0 + 19);
        Reset = 1'b1;
        #1;
        check("wrhi_gate", int'(mem_wr_en), 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        check("wrhi_mem_hi", int'(mem[10]), 8'h00);
        check("wrhi_mem_lo", int'(mem[11]), 8'h6D);
        check("wrhi_ack", int'(Ack), 0);
        check("wrhi_busy", int'(busy), 0);

        repeat (3) @(negedge Clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/recip_seq_ctrl.md
RECIP_SEQ_CTRL -- requirements
Module: recip_seq_ctrl

Interface
REQ-001 SHALL have parameter OP_ADDR, default 8'd8, byte address of divisor high byte (low byte at OP_ADDR+1).
REQ-002 SHALL have parameter RES_ADDR, default 8'd10, byte address of result high byte (low byte at RES_ADDR+1).
REQ-003 SHALL have parameter ZERO_RESULT, default 16'h0001, result written when the divisor is zero.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Start  input  1  launch request (level).
REQ-007 SHALL have port Ack  output  1  program-run-complete flag.
REQ-008 SHALL have port busy  output  1  high from leaving ARMED until entering DONE.
REQ-009 SHALL have port mem_addr  output  8  data-memory byte address.
REQ-010 SHALL have port mem_rd_data  input  8  combinational read data for mem_addr, valid in the same cycle.
REQ-011 SHALL have port mem_wr_en  output  1  byte write strobe; the write commits on the next rising edge.
REQ-012 SHALL have port mem_wr_data  output  8  byte write data.

Function
REQ-013 SHALL implement FSM states IDLE, ARMED, RD_HI, RD_LO, CHECK, DIVIDE, WR_HI, WR_LO, DONE.
REQ-014 SHALL go IDLE->ARMED on an edge sampling Start=1; ARMED holds while Start=1; ARMED->RD_HI on the first edge sampling Start=0, which defines edge E0.
REQ-015 SHALL drive mem_addr=OP_ADDR in RD_HI and OP_ADDR+1 in RD_LO, and latch mem_rd_data into divisor[15:8] or divisor[7:0] on the edge leaving each state.
REQ-016 In CHECK, SHALL go to WR_HI with result=ZERO_RESULT if divisor==0; otherwise SHALL go to DIVIDE with remainder=0, quotient=0 and step counter=15.
REQ-017 In DIVIDE, SHALL perform one restoring step per clock, MSB first, on numerator 16'h8000: rem17={rem[15:0],num_bit}; if rem17>=divisor then rem=rem17-divisor and q_bit=1, else rem=rem17 and q_bit=0; q shifts left with q_bit.
REQ-018 Remainder SHALL be 17 bits wide; divisor zero-extended; no overflow is possible.
REQ-019 SHALL leave DIVIDE after exactly 16 steps (counter 15..0), so result = floor(32768/divisor), truncated with no rounding.
REQ-020 SHALL, in WR_HI, drive mem_addr=RES_ADDR, mem_wr_data=result[15:8] and mem_wr_en=1.
REQ-021 SHALL, in WR_LO, drive mem_addr=RES_ADDR+1, mem_wr_data=result[7:0] and mem_wr_en=1.
REQ-022 mem_wr_en SHALL be 0 in all other states.
REQ-023 SHALL assert Ack only in DONE, holding it until an edge samples Start=1, then go DONE->ARMED with Ack low from that edge.
REQ-024 Latency SHALL be: nonzero divisor enters DONE on edge E21; zero divisor enters DONE on edge E5.
REQ-025 SHALL ignore Start while busy=1.
REQ-026 mem_addr SHALL be 8'h00 and mem_wr_data SHALL be 8'h00 in IDLE, ARMED and DONE.

Reset
REQ-027 SHALL, on any edge sampling Reset=1, go to IDLE with Ack=0, busy=0, divisor/quotient/remainder/counter=0, from any state including mid-DIVIDE.
REQ-028 mem_wr_en SHALL be gated combinationally by !Reset, so no memory write commits on a reset edge.
REQ-029 Reset SHALL take priority over Start when both are high.

Verification
REQ-030 SHALL verify: mem[8:9]=00,24 (36), Start 1->0 -> mem[10:11]=03,8E, Ack rises at E21.
REQ-031 SHALL verify: divisor 1 -> 80,00; divisor 4 -> 20,00; divisor FFFF -> 00,00; each at E21.
REQ-032 SHALL verify: divisor 0 -> 00,01 written, Ack rises at E5, DIVIDE never entered.
REQ-033 SHALL verify: Reset pulsed on the 8th DIVIDE cycle -> IDLE, Ack=0, mem[10:11] unchanged; a fresh launch with divisor 7 -> 12,49.
REQ-034 SHALL verify: Start pulsed mid-DIVIDE -> no effect, result correct; from DONE, Start=1 -> Ack drops next edge; back-to-back runs with divisors 3 then 300 -> 2A,AA then 00,6D.
REQ-035 SHALL verify: Reset held during WR_HI -> mem[10] not written.
